// File: rtl/conv_pkg.sv
// conv_pkg: definitions shared by the convolution layer, its output
// serializer and the tests.
//   DEF_NUM_CH / DEF_DATA_WIDTH / DEF_SHIFT : default layer geometry
//   acc_width()  : signed accumulator width derived from the pixel width
//   state_t      : serializer FSM states
//   requant()    : ReLU + saturating right-shift at the default widths
package conv_pkg;

    localparam int DEF_NUM_CH     = 64;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_SHIFT      = 6;

    // Product of two DATA_WIDTH operands plus headroom for summing
    // 3x3x3 = 27 terms (< 2^5) and one sign bit.
    function automatic int acc_width(input int data_width);
        return 2 * data_width + 6;
    endfunction

    localparam int DEF_ACC_WIDTH = 2 * DEF_DATA_WIDTH + 6;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Non-positive inputs clamp to 0, positive inputs are shifted right
    // (truncating) and clamped to the largest unsigned DATA_WIDTH value.
    function automatic logic [DEF_DATA_WIDTH-1:0] requant(
        input logic signed [DEF_ACC_WIDTH-1:0] v,
        input int                              shift
    );
        logic [DEF_ACC_WIDTH-1:0] r;
        if (v <= 0) begin
            return '0;
        end
        r = DEF_ACC_WIDTH'(v >>> shift);
        if (r > DEF_ACC_WIDTH'((1 << DEF_DATA_WIDTH) - 1)) begin
            return '1;
        end
        return r[DEF_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/conv_out_requant_serializer_relu_requant.sv
// relu_requant: purely combinational ReLU + saturating right-shift
// requantisation of one signed conv result.
//   acc_in : signed ACC_WIDTH conv result (two's complement)
//   q_out  : unsigned DATA_WIDTH requantised value
module relu_requant
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH),
    parameter int SHIFT      = DEF_SHIFT
) (
    input  logic [ACC_WIDTH-1:0]  acc_in,
    output logic [DATA_WIDTH-1:0] q_out
);

    logic                 non_positive;
    logic [ACC_WIDTH-1:0] shifted;
    logic                 overflow;

    // Sign bit set or all-zero means ReLU clamps to 0.
    assign non_positive = acc_in[ACC_WIDTH-1] || (acc_in == '0);

    // Only reached for positive values, so a logical shift equals the
    // arithmetic one and the upper bits come in as zero.
    assign shifted  = acc_in >> SHIFT;
    assign overflow = |shifted[ACC_WIDTH-1:DATA_WIDTH];

    always_comb begin
        q_out = shifted[DATA_WIDTH-1:0];
        if (non_positive) begin
            q_out = '0;
        end else if (overflow) begin
            q_out = '1;
        end
    end

endmodule

// File: rtl/conv_out_requant_serializer.sv
// conv_out_requant_serializer: captures one frame of NUM_CH signed conv
// results, requantises each to DATA_WIDTH bits and streams them out one
// channel per cycle over valid/ready.
//   clk, rst (async, active-low)
//   conv_valid, conv_outs : frame input, channel i at [(i+1)*ACC_WIDTH-1 -: ACC_WIDTH]
//   out_data, out_ch, out_last, out_valid, out_ready : output stream
//   busy          : high while a frame is being sent
//   frame_dropped : sticky, set when a frame arrives mid-send
module conv_out_requant_serializer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ACC_WIDTH  = acc_width(DATA_WIDTH),
    parameter int SHIFT      = DEF_SHIFT,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        conv_valid,
    input  logic [NUM_CH*ACC_WIDTH-1:0] conv_outs,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        frame_dropped
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [DATA_WIDTH-1:0] rq [NUM_CH];

    state_t                state_reg;
    logic [CH_W-1:0]       idx_reg;
    logic [DATA_WIDTH-1:0] buf_reg [NUM_CH];
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic [CH_W-1:0]       out_ch_reg;
    logic                  out_valid_reg;
    logic                  out_last_reg;
    logic                  busy_reg;
    logic                  frame_dropped_reg;

    logic [CH_W-1:0]       idx_next;
    logic                  final_hs;
    logic                  capture;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rq
            relu_requant #(
                .DATA_WIDTH(DATA_WIDTH),
                .ACC_WIDTH (ACC_WIDTH),
                .SHIFT     (SHIFT)
            ) u_relu_requant (
                .acc_in(conv_outs[(gi+1)*ACC_WIDTH-1 -: ACC_WIDTH]),
                .q_out (rq[gi])
            );
        end
    endgenerate

    assign idx_next = idx_reg + 1'b1;
    // In SEND out_valid is always 1, so out_ready alone completes a beat.
    assign final_hs = (state_reg == SEND) && out_ready && (idx_reg == LAST_CH);
    // A new frame is accepted when idle or exactly on the last handshake,
    // which lets frames run back-to-back without a bubble.
    assign capture  = conv_valid && ((state_reg == IDLE) || final_hs);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            idx_reg           <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                buf_reg[i] <= '0;
            end
            out_data_reg      <= '0;
            out_ch_reg        <= '0;
            out_valid_reg     <= 1'b0;
            out_last_reg      <= 1'b0;
            busy_reg          <= 1'b0;
            frame_dropped_reg <= 1'b0;
        end else begin
            if (capture) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    buf_reg[i] <= rq[i];
                end
                // Channel 0 comes straight from the requant outputs since
                // the buffer is only being written on this edge.
                state_reg     <= SEND;
                idx_reg       <= '0;
                out_data_reg  <= rq[0];
                out_ch_reg    <= '0;
                out_valid_reg <= 1'b1;
                out_last_reg  <= (LAST_CH == '0);
                busy_reg      <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                end
                SEND: begin
                    if (conv_valid && !final_hs) begin
                        frame_dropped_reg <= 1'b1;
                    end
                    if (out_ready) begin
                        if (idx_reg == LAST_CH) begin
                            if (!conv_valid) begin
                                state_reg     <= IDLE;
                                idx_reg       <= '0;
                                out_data_reg  <= '0;
                                out_ch_reg    <= '0;
                                out_valid_reg <= 1'b0;
                                out_last_reg  <= 1'b0;
                                busy_reg      <= 1'b0;
                            end
                        end else begin
                            idx_reg      <= idx_next;
                            out_data_reg <= buf_reg[idx_next];
                            out_ch_reg   <= idx_next;
                            out_last_reg <= (idx_next == LAST_CH);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_data      = out_data_reg;
    assign out_ch        = out_ch_reg;
    assign out_valid     = out_valid_reg;
    assign out_last      = out_last_reg;
    assign busy          = busy_reg;
    assign frame_dropped = frame_dropped_reg;

endmodule

// File: doc/conv_out_requant_serializer.md
# conv_out_requant_serializer

Downstream stage of the 64-filter RGB convolution layer. It captures one frame of 64 signed convolution results on a `conv_valid` pulse. Each result is passed through ReLU and a saturating right-shift requantisation to `DATA_WIDTH` bits. The 64 bytes then stream out one channel per cycle over a valid/ready interface to the next layer or to the DMA writer.

## Interface
Parameters:
- `DATA_WIDTH`, 8: pixel/output width.
- `NUM_CH`, 64: number of parallel conv channels.
- `ACC_WIDTH`, 2*DATA_WIDTH+6 (22): signed width of each conv result.
- `SHIFT`, 6: requantisation right-shift amount, 0..ACC_WIDTH-2.
- `CH_W`, $clog2(NUM_CH) (6): channel index width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `conv_valid`, in, 1: single-cycle pulse marking `conv_outs` as valid.
- `conv_outs`, in, NUM_CH*ACC_WIDTH: channel i occupies `[(i+1)*ACC_WIDTH-1 -: ACC_WIDTH]`, two's complement.
- `out_data`, out, DATA_WIDTH: requantised value of the current channel, unsigned.
- `out_ch`, out, CH_W: index of the current channel.
- `out_valid`, out, 1: `out_data`/`out_ch`/`out_last` are valid.
- `out_ready`, in, 1: consumer accepts the current beat.
- `out_last`, out, 1: high on the beat where `out_ch == NUM_CH-1`.
- `busy`, out, 1: high while in SEND.
- `frame_dropped`, out, 1: sticky flag, set when a frame is rejected; cleared only by reset.

## Operation
Requantisation, applied per channel at capture:
- If v <= 0, result is 0 (ReLU).
- Otherwise r = v >>> SHIFT, truncating.
- If r > 2^DATA_WIDTH-1, result saturates to 2^DATA_WIDTH-1.
- The capture buffer stores NUM_CH x DATA_WIDTH requantised bytes.

FSM states: IDLE, SEND.
- IDLE: `conv_valid` causes capture of all channels, `idx`=0, transition to SEND.
- SEND: `out_valid`=1, `out_data`=buf[idx], `out_ch`=idx.
  - Handshake occurs when `out_valid && out_ready`. On a handshake with idx < NUM_CH-1, idx increments.
  - On a handshake with idx == NUM_CH-1, the block returns to IDLE.
- Backpressure: while `out_valid && !out_ready`, all outputs hold stable and idx does not change.
- `conv_valid` in SEND, except on the final handshake cycle: frame discarded, buffer untouched, `frame_dropped` set to 1.
- `conv_valid` coinciding with the final handshake (idx==NUM_CH-1, `out_ready`=1): new frame captured, idx=0, state stays SEND, no drop. This gives back-to-back frames with no bubble.
- All outputs are driven from registers only. There is no combinational path from any input to any output.

## Timing
- Reset values: state IDLE, idx 0, buffer all 0, `out_valid` 0, `out_data` 0, `out_ch` 0, `out_last` 0, `busy` 0, `frame_dropped` 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). After release the block sits in IDLE and waits for a new `conv_valid`.
- Latency: `conv_valid` sampled at edge N gives `out_valid`=1 with channel 0 after edge N, i.e. visible in cycle N+1.
- Throughput: NUM_CH cycles per frame when `out_ready` is held at 1.
- Frame ordering is strictly channel 0 to NUM_CH-1. No beat is skipped or repeated.

## Structure
- Shared package `conv_pkg` holds:
  - `NUM_CH` and `DATA_WIDTH` defaults.
  - The `ACC_WIDTH` derivation function.
  - The FSM state typedef (`IDLE`, `SEND`).
  - The `requant` function, so the conv layer and the tests share one definition.
- Sub-module `relu_requant`: purely combinational, ACC_WIDTH in to DATA_WIDTH out. It is instantiated NUM_CH times in a generate loop feeding the capture buffer.
- The top level contains the FSM, the index counter, the buffer and the output registers.

## Test plan
- Single frame with channel i = i*64 and `out_ready`=1 -> 64 beats in consecutive cycles, data = i (SHIFT=6), `out_last` only at ch 63, `busy` drops after the last beat.
- Boundary values: channel 0 = -5 → 0; channel 1 = 0 → 0; channel 2 = 63 → 0; channel 3 = 16383 → 255; channel 4 = 2^21-1 → 255 (saturate); channel 5 = -2^21 → 0.
- Random `out_ready` backpressure (50%) -> sequence and data identical to the no-backpressure run; outputs stable in every stalled cycle.
- `conv_valid` pulsed at ch 10 of an active frame -> remaining beats unchanged, `frame_dropped`=1 stays set.
- `conv_valid` on the final-handshake cycle -> ch 0 of the new frame appears in the next cycle, no bubble, `frame_dropped` stays 0.
- `rst` asserted low at ch 30 -> all outputs immediately at their reset values; a new `conv_valid` after release streams a full frame from ch 0.
